// File: rtl/clock_logic_pkg.sv
// Shared widths, vote helper and saturation constant for the TMR phase generator.
// Channel state is {ph, pre}; its struct is built in the top from these widths.
package clock_logic_pkg;

   function automatic int ph_w(input int phases);
      return (phases <= 2) ? 1 : $clog2(phases);
   endfunction

   function automatic int pre_w(input int div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // All-ones value of a w-bit error counter.
   function automatic logic [63:0] err_sat(input int w);
      return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
   endfunction

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 voter with per-copy miscompare flags.
// Used on the packed channel state of the phase generator.
module tmr_vote
   import clock_logic_pkg::*;
#(
   parameter int W = 1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] v,
   output logic [2:0]   mis
);

   for (genvar k = 0; k < W; k++) begin : g_bit
      assign v[k] = maj3(a[k], b[k], c[k]);
   end

   assign mis = {c != v, b != v, a != v};

endmodule

// File: rtl/tmr_phase_generator.sv
// Triple-redundant one-hot phase generator with vote scrubbing and fault tracking.
// Optional macro TMR_FAULT_INJECT_EN adds INJ_EN / INJ_CH for ph-LSB upset injection.
module tmr_phase_generator
   import clock_logic_pkg::*;
#(
   parameter int PHASES    = 4,
   parameter int DIV       = 1,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 SIM_CLK,
   input  logic                 SIM_RST,
`ifdef TMR_FAULT_INJECT_EN
   input  logic                 INJ_EN,
   input  logic [1:0]           INJ_CH,
`endif
   input  logic [2:0]           ADV,
   input  logic                 FAULT_CLR,
   output logic [PHASES-1:0]    PHASE,
   output logic [PHASES-1:0]    PHASE_N,
   output logic                 WRAP,
   output logic [2:0]           CH_FAULT,
   output logic                 STROBE_MISMATCH,
   output logic [ERR_CNT_W-1:0] ERR_CNT
);

   localparam int PH_W  = ph_w(PHASES);
   localparam int PRE_W = pre_w(DIV);
   localparam int SW    = PH_W + PRE_W;

   localparam logic [PH_W-1:0]      PH_LAST  = PH_W'(PHASES - 1);
   localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(DIV - 1);
   localparam logic [ERR_CNT_W-1:0] ERR_SAT  = ERR_CNT_W'(err_sat(ERR_CNT_W));

   typedef struct packed {
      logic [PH_W-1:0]  ph;
      logic [PRE_W-1:0] pre;
   } chan_t;

   chan_t      st    [3];
   chan_t      nx_ch [3];
   chan_t      vs;
   chan_t      nxt;
   logic [SW-1:0] vs_raw;
   logic [2:0] mis;
   logic       adv_v;
   logic       step;
   logic       wrap_nx;

   tmr_vote #(.W(SW)) u_vote (
      .a   (st[0]),
      .b   (st[1]),
      .c   (st[2]),
      .v   (vs_raw),
      .mis (mis)
   );

   assign vs      = chan_t'(vs_raw);
   assign adv_v   = maj3(ADV[0], ADV[1], ADV[2]);
   assign step    = adv_v && (vs.pre == PRE_LAST);
   assign wrap_nx = step && (vs.ph == PH_LAST);

   always_comb begin
      nxt = vs;
      if (step) begin
         nxt.pre = '0;
         nxt.ph  = (vs.ph == PH_LAST) ? '0 : vs.ph + PH_W'(1);
      end else if (adv_v) begin
         nxt.pre = vs.pre + PRE_W'(1);
      end
   end

   // Injected upset lands on one copy only; the vote scrubs it next edge.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         nx_ch[i] = nxt;
`ifdef TMR_FAULT_INJECT_EN
         if (INJ_EN && INJ_CH == 2'(i))
            nx_ch[i].ph[0] = ~nxt.ph[0];
`endif
      end
   end

   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         for (int i = 0; i < 3; i++)
            st[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++)
            st[i] <= nx_ch[i];
      end
   end

   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         WRAP            <= 1'b0;
         STROBE_MISMATCH <= 1'b0;
      end else begin
         WRAP            <= wrap_nx;
         STROBE_MISMATCH <= (ADV != 3'b000) && (ADV != 3'b111);
      end
   end

   // A fresh miscompare outranks a same-cycle clear.
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         CH_FAULT <= '0;
         ERR_CNT  <= '0;
      end else begin
         CH_FAULT <= FAULT_CLR ? mis : (CH_FAULT | mis);
         if (|mis) begin
            if (FAULT_CLR)
               ERR_CNT <= ERR_CNT_W'(1);
            else if (ERR_CNT != ERR_SAT)
               ERR_CNT <= ERR_CNT + ERR_CNT_W'(1);
         end else if (FAULT_CLR) begin
            ERR_CNT <= '0;
         end
      end
   end

   assign PHASE   = PHASES'(1) << vs.ph;
   assign PHASE_N = ~PHASE;

endmodule

// File: tb/tb_tmr_phase_generator.sv
// Directed bench for tmr_phase_generator: count, wrap, strobe vote, reset.
// Injection, clear-race and saturation vectors run when TMR_FAULT_INJECT_EN is set.
module tb_tmr_phase_generator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] adv = 3'b000;
   logic       fault_clr = 1'b0;
   logic       inj_en = 1'b0;
   logic [1:0] inj_ch = 2'd0;
   logic [3:0] phase;
   logic [3:0] phase_n;
   logic       wrap;
   logic [2:0] ch_fault;
   logic       strobe_mismatch;
   logic [1:0] err_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tmr_phase_generator #(
      .PHASES    (4),
      .DIV       (2),
      .ERR_CNT_W (2)
   ) dut (
      .SIM_CLK         (clk),
      .SIM_RST         (rst_n),
`ifdef TMR_FAULT_INJECT_EN
      .INJ_EN          (inj_en),
      .INJ_CH          (inj_ch),
`endif
      .ADV             (adv),
      .FAULT_CLR       (fault_clr),
      .PHASE           (phase),
      .PHASE_N         (phase_n),
      .WRAP            (wrap),
      .CH_FAULT        (ch_fault),
      .STROBE_MISMATCH (strobe_mismatch),
      .ERR_CNT         (err_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      adv = 3'b111;
      tick();
      adv = 3'b000;
      tick();
   endtask

   initial begin
      logic [3:0] exp_ph;
      tick();
      tick();
      check("rst_phase", 32'(phase), 32'h1);
      check("rst_phase_n", 32'(phase_n), 32'he);
      check("rst_wrap", 32'(wrap), 32'h0);
      check("rst_fault", 32'(ch_fault), 32'h0);
      check("rst_err", 32'(err_cnt), 32'h0);
      check("rst_smis", 32'(strobe_mismatch), 32'h0);
      rst_n = 1'b1;
      tick();

      // DIV=2: one phase step per two strobes, wrap after strobe 8
      for (int k = 1; k <= 8; k++) begin
         exp_ph = 4'b0001 << ((k / 2) % 4);
         adv = 3'b111;
         tick();
         check($sformatf("cnt_phase%0d", k), 32'(phase), 32'(exp_ph));
         check($sformatf("cnt_wrap%0d", k), 32'(wrap), 32'(k == 8));
         adv = 3'b000;
         tick();
         check($sformatf("cnt_wrap_off%0d", k), 32'(wrap), 32'h0);
      end
      check("cnt_phase_n", 32'(phase_n), 32'he);

      adv = 3'b110;
      tick();
      check("drop_smis", 32'(strobe_mismatch), 32'h1);
      check("drop_fault", 32'(ch_fault), 32'h0);
      adv = 3'b000;
      tick();
      check("drop_smis_off", 32'(strobe_mismatch), 32'h0);
      adv = 3'b001;
      tick();
      check("minor_smis", 32'(strobe_mismatch), 32'h1);
      check("minor_phase", 32'(phase), 32'h1);
      adv = 3'b000;
      tick();
      adv = 3'b111;
      tick();
      check("drop_adv_phase", 32'(phase), 32'h2);
      check("full_smis", 32'(strobe_mismatch), 32'h0);
      adv = 3'b000;
      tick();

`ifdef TMR_FAULT_INJECT_EN
      inj_en = 1'b1;
      inj_ch = 2'd1;
      tick();
      inj_en = 1'b0;
      check("inj_phase", 32'(phase), 32'h2);
      check("inj_fault_pre", 32'(ch_fault), 32'h0);
      tick();
      check("inj_fault", 32'(ch_fault), 32'h2);
      check("inj_err", 32'(err_cnt), 32'h1);
      check("inj_phase2", 32'(phase), 32'h2);
      tick();
      check("inj_scrubbed", 32'(err_cnt), 32'h1);

      inj_en = 1'b1;
      inj_ch = 2'd2;
      tick();
      inj_en = 1'b0;
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      check("race_fault", 32'(ch_fault), 32'h4);
      check("race_err", 32'(err_cnt), 32'h1);
      tick();
      check("race_hold", 32'(err_cnt), 32'h1);

      inj_en = 1'b1;
      inj_ch = 2'd3;
      tick();
      inj_en = 1'b0;
      tick();
      check("ch3_err", 32'(err_cnt), 32'h1);
      check("ch3_fault", 32'(ch_fault), 32'h4);

      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      check("clr_fault", 32'(ch_fault), 32'h0);
      check("clr_err", 32'(err_cnt), 32'h0);

      for (int n = 1; n <= 5; n++) begin
         inj_en = 1'b1;
         inj_ch = 2'd0;
         tick();
         inj_en = 1'b0;
         tick();
         check($sformatf("sat_err%0d", n), 32'(err_cnt), (n < 3) ? 32'(n) : 32'd3);
      end
      tick();
      check("sat_hold", 32'(err_cnt), 32'h3);
      check("sat_fault", 32'(ch_fault), 32'h1);
      check("sat_phase", 32'(phase), 32'h2);
`endif

      pulse();
      pulse();
      check("pre_rst_phase", 32'(phase), 32'h4);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_phase", 32'(phase), 32'h1);
      check("async_err", 32'(err_cnt), 32'h0);
      check("async_wrap", 32'(wrap), 32'h0);
      check("async_fault", 32'(ch_fault), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      check("rel_wrap", 32'(wrap), 32'h0);
      pulse();
      check("rel_phase1", 32'(phase), 32'h1);
      pulse();
      check("rel_phase2", 32'(phase), 32'h2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tmr_phase_generator.md
Name: tmr_phase_generator

Overview:
- Parametrised triple-redundant timing-phase generator for the LVDC simulation.
- Three channel copies each hold a prescaler and phase counter. Each copy reloads every cycle from the bitwise 2-of-3 vote of all three.
- The copies advance on a voted strobe and drive one-hot phase clocks to downstream logic.
- Adds generic phase count and divide ratio, sticky per-channel fault flags, strobe-disagreement detection and a saturating error counter.

Parameters:
- PHASES, 4, number of phases; must be >= 2.
- DIV, 1, voted strobes per phase step; must be >= 1.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- SIM_CLK  input  1  system clock; all state changes on rising edge.
- SIM_RST  input  1  reset, asynchronous, active-low.
- ADV  input  3  per-channel advance strobes (oscillator-derived), one per channel.
- FAULT_CLR  input  1  clears CH_FAULT and ERR_CNT.
- PHASE  output  PHASES  one-hot voted phase.
- PHASE_N  output  PHASES  bitwise complement of PHASE.
- WRAP  output  1  one-cycle pulse on phase wrap to 0.
- CH_FAULT  output  3  sticky per-channel state-miscompare flags.
- STROBE_MISMATCH  output  1  registered pulse; ADV bits disagreed.
- ERR_CNT  output  ERR_CNT_W  saturating count of cycles with any channel miscompare.

Behaviour:
- Widths:
  - PH_W = max(1, clog2(PHASES)).
  - PRE_W = max(1, clog2(DIV)).
  - Channel state = {ph, pre}.
- Vote:
  - vs = bitwise majority of the three channel states (combinational from flops).
  - adv_v = majority(ADV[2:0]).
- Next state, identical for all channels:
  - If adv_v and pre_v == DIV-1: pre = 0, ph = (ph_v == PHASES-1) ? 0 : ph_v+1.
  - Else if adv_v: pre = pre_v+1, ph = ph_v.
  - Else: state = vs. This is a scrub; a single upset is corrected at the next edge.
- PHASE:
  - PHASE = decode(ph of vs), combinational off registers.
  - PHASE changes in the same cycle as the state edge; no extra latency.
  - With DIV = 1, the phase advances on every voted strobe.
- WRAP: registered. Set for exactly one cycle after an edge where adv_v && pre_v == DIV-1 && ph_v == PHASES-1. It coincides with the first cycle of PHASE[0].
- Miscompare:
  - mis[i] = (state_i != vs), evaluated each cycle.
  - CH_FAULT[i] sets at the next edge and stays set until FAULT_CLR.
- ERR_CNT:
  - Increments by 1 per cycle in which any mis[i] is set.
  - Saturates at all-ones; no wrap.
- STROBE_MISMATCH: registered; 1 for one cycle after any cycle in which ADV is not 000 or 111.
- FAULT_CLR:
  - Synchronous; clears CH_FAULT and ERR_CNT.
  - If a mismatch occurs in the same cycle, the new fault wins: CH_FAULT bit sets and ERR_CNT loads 1.
- Double upset (two channels corrupted identically): the vote follows the corrupted value. The healthy channel is flagged. No recovery beyond the vote.
- Reset (SIM_RST low, any time, including mid-count):
  - All channel ph = 0, pre = 0.
  - PHASE = 1 (bit 0), PHASE_N = ~1.
  - WRAP = 0, CH_FAULT = 0, STROBE_MISMATCH = 0, ERR_CNT = 0.
- Release: the first ADV after reset release counts normally. No WRAP is generated by reset itself.

Optional Feature:
- Macro: TMR_FAULT_INJECT_EN.
- When defined, adds two inputs:
  - INJ_EN (1).
  - INJ_CH (2).
- With INJ_EN = 1 and INJ_CH in 0..2, the next-state of that channel has ph LSB inverted for that edge only. INJ_CH = 3 has no effect.
- The corrupted channel is scrubbed on the following edge and its CH_FAULT sets.
- When undefined: no ports, no logic; behaviour as above.

Decomposition:
- Package clock_logic_pkg:
  - Width functions PH_W / PRE_W.
  - Function maj3 (bitwise majority).
  - Typedef for channel state struct {ph, pre}.
  - Constant for error-counter saturation.
- One sub-module, tmr_vote:
  - Parametrised width W.
  - Three inputs; outputs voted value and 3-bit miscompare.
  - Instanced for channel state.

Test Plan:
- Reset: SIM_RST low mid-count at phase 2 -> PHASE = 0001, ERR_CNT = 0, WRAP = 0, immediately and asynchronously.
- Count (PHASES=4, DIV=2): ADV=111 on 8 pulses -> PHASE steps 0001, 0010, 0100, 1000 every 2 strobes; WRAP high 1 cycle with PHASE = 0001 after pulse 8.
- Single strobe drop: ADV=110 for one strobe -> channels still advance; STROBE_MISMATCH pulses 1 cycle; CH_FAULT = 000.
- Inject: TMR_FAULT_INJECT_EN, INJ_CH=1 at phase 1 -> PHASE unaffected; CH_FAULT = 010; ERR_CNT = 1; channel 1 equals vote 1 cycle later.
- Clear race: FAULT_CLR together with inject on channel 2 -> CH_FAULT = 100, ERR_CNT = 1.
- Saturation (ERR_CNT_W=2): 5 separate injects -> ERR_CNT = 3, holds at 3.
